// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Registers the granted command and routes the RAM read data back to its owner.
module onchip_memory_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t state;
    logic   grant;
    logic   last_grant;
    logic   req0;
    logic   req1;
    logic   pick;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    // With both requesting, the master that was not served last wins.
    assign pick = (req0 && req1) ? ~last_grant : req1;

    assign m0_waitrequest = !(state == ACCESS && grant == 1'b0);
    assign m1_waitrequest = !(state == ACCESS && grant == 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            grant            <= 1'b0;
            last_grant       <= 1'b1;
            mem_address      <= '0;
            mem_byteenable   <= '0;
            mem_chipselect   <= 1'b0;
            mem_write        <= 1'b0;
            mem_writedata    <= '0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant          <= pick;
                        last_grant     <= pick;
                        mem_chipselect <= 1'b1;
                        mem_address    <= pick ? m1_address    : m0_address;
                        mem_byteenable <= pick ? m1_byteenable : m0_byteenable;
                        mem_writedata  <= pick ? m1_writedata  : m0_writedata;
                        mem_write      <= pick ? m1_write      : m0_write;
                        state          <= ACCESS;
                    end else begin
                        mem_chipselect <= 1'b0;
                    end
                end
                ACCESS: begin
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                    state          <= mem_write ? IDLE : RDATA;
                end
                RDATA: begin
                    // RAM q is valid this cycle for the command sampled at the end of ACCESS.
                    if (grant) begin
                        m1_readdata      <= mem_readdata;
                        m1_readdatavalid <= 1'b1;
                    end else begin
                        m0_readdata      <= mem_readdata;
                        m0_readdatavalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Randomised bench for onchip_memory_arbiter: a transaction-level model predicts
// grants, RAM commands and read returns; a few literal checks pin the model.
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  addr [2];
    logic [3:0]  be [2];
    logic        rd [2];
    logic        wr [2];
    logic [31:0] wd [2];
    logic        waitreq [2];
    logic [31:0] rdata [2];
    logic        rdv [2];
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    onchip_memory_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(addr[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
        .m0_writedata(wd[0]), .m0_waitrequest(waitreq[0]), .m0_readdata(rdata[0]),
        .m0_readdatavalid(rdv[0]),
        .m1_address(addr[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
        .m1_writedata(wd[1]), .m1_waitrequest(waitreq[1]), .m1_readdata(rdata[1]),
        .m1_readdatavalid(rdv[1]),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: address registered on the edge, q valid the following cycle.
    logic [31:0] ram [1024] = '{default: 32'h0};
    logic [31:0] ram_q = 32'h0;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: the arbiter is free from cycle free_at on; a command seen
    // while free is accepted the next cycle, reads return two cycles after acceptance.
    logic [31:0] shadow [1024] = '{default: 32'h0};
    logic [31:0] exp_rd [2];
    int          last_m, free_at, acc_cyc, acc_m, rdv_cyc, rdv_m;
    bit          acc_wr;
    logic [9:0]  acc_addr;
    logic [3:0]  acc_be;
    logic [31:0] acc_wd, rdv_val;
    int          obs_m [$];
    int          obs_c [$];
    int          rdv_seen [2] = '{0, 0};

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("rst_wait%0d", i), 32'(waitreq[i]), 32'd1);
                checkOutput($sformatf("rst_rdv%0d", i), 32'(rdv[i]), 32'd0);
                checkOutput($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
                exp_rd[i] = 32'h0;
            end
            checkOutput("rst_cs", 32'(mem_chipselect), 32'd0);
            checkOutput("rst_mwr", 32'(mem_write), 32'd0);
            last_m = 1; free_at = cyc + 1; acc_cyc = -1; rdv_cyc = -1;
        end else begin
            if (cyc == rdv_cyc) exp_rd[rdv_m] = rdv_val;
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("wait%0d", i), 32'(waitreq[i]),
                            32'(!(cyc == acc_cyc && acc_m == i)));
                checkOutput($sformatf("rdv%0d", i), 32'(rdv[i]),
                            32'(cyc == rdv_cyc && rdv_m == i));
                checkOutput($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
                if (!waitreq[i]) begin
                    obs_m.push_back(i);
                    obs_c.push_back(cyc);
                end
                if (rdv[i]) rdv_seen[i]++;
            end
            checkOutput("mem_cs", 32'(mem_chipselect), 32'(cyc == acc_cyc));
            checkOutput("mem_wr", 32'(mem_write), 32'(cyc == acc_cyc && acc_wr));
            if (cyc == acc_cyc) begin
                checkOutput("mem_addr", 32'(mem_address), 32'(acc_addr));
                if (acc_wr) begin
                    checkOutput("mem_be", 32'(mem_byteenable), 32'(acc_be));
                    checkOutput("mem_wd", mem_writedata, acc_wd);
                end
            end
            if (cyc >= free_at && (rd[0] || wr[0] || rd[1] || wr[1])) begin
                if ((rd[0] || wr[0]) && (rd[1] || wr[1])) acc_m = 1 - last_m;
                else acc_m = (rd[1] || wr[1]) ? 1 : 0;
                last_m = acc_m;
                acc_cyc = cyc + 1;
                acc_wr = wr[acc_m];
                acc_addr = addr[acc_m];
                acc_be = be[acc_m];
                acc_wd = wd[acc_m];
                if (acc_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (acc_be[b]) shadow[acc_addr][b*8 +: 8] = acc_wd[b*8 +: 8];
                    free_at = cyc + 2;
                end else begin
                    rdv_val = shadow[acc_addr];
                    rdv_m = acc_m;
                    rdv_cyc = cyc + 3;
                    free_at = cyc + 3;
                end
            end
        end
    end

    // Issue one command at posedge+1 and hold it until accepted; returns at posedge+1.
    task automatic applyStimulus(input int m, input bit r, input bit w, input logic [9:0] a,
                                 input logic [3:0] b, input logic [31:0] d, output int acc);
        bit got = 0;
        addr[m] = a; be[m] = b; wd[m] = d; rd[m] = r; wr[m] = w;
        acc = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (!waitreq[m]) begin
                got = 1;
                acc = cyc;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL accept_timeout m%0d: got no accept expected accept", m);
        end
        @(posedge clk); #1;
        rd[m] = 1'b0; wr[m] = 1'b0;
    endtask

    task automatic waitReadData(input int m, output logic [31:0] d, output int c);
        bit got = 0;
        d = 32'h0; c = -1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdv[m]) begin
                got = 1; d = rdata[m]; c = cyc;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL rdv_timeout m%0d: got no readdatavalid expected pulse", m);
        end
        @(posedge clk); #1;
    endtask

    task automatic randomMaster(input int m, input int n);
        int acc;
        for (int t = 0; t < n; t++) begin
            int gap = $urandom_range(0, 3);
            int kind = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            applyStimulus(m, kind != 2, kind >= 2, 10'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), $urandom, acc);
        end
    endtask

    initial begin
        int a1, a2, rc, base, seen;
        logic [31:0] d;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; be[i] = '0; rd[i] = 0; wr[i] = 0; wd[i] = '0;
        end
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        // Reset held with both masters requesting reads.
        rd[0] = 1; rd[1] = 1; addr[0] = 10'd3; addr[1] = 10'd4;
        repeat (3) @(negedge clk);
        checkOutput("t1_wait0", 32'(waitreq[0]), 32'd1);
        checkOutput("t1_wait1", 32'(waitreq[1]), 32'd1);
        checkOutput("t1_cs", 32'(mem_chipselect), 32'd0);
        @(posedge clk); #1;
        base = obs_m.size();
        reset_n = 1'b1;
        repeat (14) @(posedge clk);
        #1 rd[0] = 0; rd[1] = 0;
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t4_order%0d", i), 32'(obs_m[base + i]), 32'(i % 2));

        applyStimulus(0, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF, a1);
        applyStimulus(0, 1, 0, 10'h005, 4'hF, 32'h0, a1);
        waitReadData(0, d, rc);
        checkOutput("t2_rdata", d, 32'hDEADBEEF);
        checkOutput("t2_latency", 32'(rc - a1), 32'd2);

        seen = rdv_seen[0];
        applyStimulus(1, 0, 1, 10'h005, 4'b0010, 32'h0000AB00, a1);
        applyStimulus(1, 1, 0, 10'h005, 4'hF, 32'h0, a1);
        waitReadData(1, d, rc);
        checkOutput("t3_rdata", d, 32'hDEADABEF);
        checkOutput("t3_m0_quiet", 32'(rdv_seen[0] - seen), 32'd0);

        base = obs_m.size();
        applyStimulus(1, 1, 0, 10'h005, 4'hF, 32'h0, a1);
        applyStimulus(1, 1, 0, 10'h006, 4'hF, 32'h0, a2);
        checkOutput("t5_gap", 32'(a2 - a1), 32'd3);
        checkOutput("t5_owner", 32'(obs_m[base + 1]), 32'd1);
        repeat (4) begin @(posedge clk); #1; end

        seen = rdv_seen[0];
        applyStimulus(0, 1, 0, 10'h005, 4'hF, 32'h0, a1);
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("t6_no_rdv", 32'(rdv_seen[0] - seen), 32'd0);
        applyStimulus(0, 1, 0, 10'h005, 4'hF, 32'h0, a1);
        waitReadData(0, d, rc);
        checkOutput("t6_rdata", d, 32'hDEADABEF);

        fork
            randomMaster(0, 80);
            randomMaster(1, 80);
        join
        repeat (6) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
